// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared definitions for the decoder scan controller.
// Holds the FSM state encodings, the decoder channel constants and a
// lowest-set-bit helper used by the channel selector.
package decoder_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GAP    = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [1:0] CH0 = 2'd0;
    localparam logic [1:0] CH1 = 2'd1;
    localparam logic [1:0] CH2 = 2'd2;
    localparam logic [1:0] CH3 = 2'd3;

    // Lowest set channel of a 4-bit enable mask; CH0 when the mask is empty.
    function automatic logic [1:0] low_ch(input logic [3:0] m);
        if (m[0])      return CH0;
        else if (m[1]) return CH1;
        else if (m[2]) return CH2;
        else if (m[3]) return CH3;
        else           return CH0;
    endfunction

endpackage

// File: rtl/decoder_scan_ctrl_next_ch_sel.sv
// Combinational channel selector for the decoder scan controller.
// Ports:
//   mask  in  4  channel enables
//   cur   in  2  current channel
//   nxt   out 2  next enabled channel above cur (lowest enabled one on wrap)
//   wrap  out 1  no enabled channel above cur
//   first out 2  lowest enabled channel
//   none  out 1  mask is empty
module next_ch_sel
    import decoder_scan_ctrl_pkg::*;
(
    input  logic [3:0] mask,
    input  logic [1:0] cur,
    output logic [1:0] nxt,
    output logic       wrap,
    output logic [1:0] first,
    output logic       none
);

    logic [3:0] above;

    always_comb begin
        above = 4'd0;
        for (int i = 0; i < 4; i++) begin
            above[i] = mask[i] && (i > int'(cur));
        end
        none  = (mask == 4'd0);
        first = low_ch(mask);
        wrap  = (above == 4'd0);
        nxt   = wrap ? first : low_ch(above);
    end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer driving the G_L/A/B inputs of a v74x139 2-to-4 decoder.
// Steps through the enabled channels, holding each active for DWELL+1
// cycles with a GAP_CYC-cycle blanking gap before every window so that the
// select lines only move while the decoder is disabled.
// Ports:
//   CLK      in   1      clock, rising edge
//   RESET_L  in   1      async active-low reset
//   START    in   1      begin a sweep (ignored while BUSY)
//   STOP     in   1      synchronous abort, highest priority
//   ONESHOT  in   1      1: single sweep, 0: continuous
//   MASK     in   4      channel enables
//   DWELL    in   CNT_W  active window length minus one
//   G_L      out  1      decoder enable, active low
//   A, B     out  1      decoder select, {B,A} = channel
//   BUSY     out  1      not idle
//   DONE     out  1      one-cycle pulse at each sweep end
module decoder_scan_ctrl
    import decoder_scan_ctrl_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int GAP_CYC = 2
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             START,
    input  logic             STOP,
    input  logic             ONESHOT,
    input  logic [3:0]       MASK,
    input  logic [CNT_W-1:0] DWELL,
    output logic             G_L,
    output logic             A,
    output logic             B,
    output logic             BUSY,
    output logic             DONE
);

    state_t           state, state_n;
    logic [3:0]       gap_cnt, gap_n;
    logic [CNT_W-1:0] dwell_cnt, dwell_n;
    logic [3:0]       mask_r, mask_n;
    logic             wrapped, wrapped_n;
    logic [1:0]       ch, ch_n;
    logic             g_l_n, done_n;

    logic [3:0]       sel_mask;
    logic [1:0]       sel_nxt, sel_first;
    logic             sel_wrap, sel_none;

    // In IDLE the selector looks at the live MASK so START can pick the
    // first channel on the same edge; otherwise it uses the registered mask.
    assign sel_mask = (state == IDLE) ? MASK : mask_r;

    next_ch_sel u_sel (
        .mask  (sel_mask),
        .cur   (ch),
        .nxt   (sel_nxt),
        .wrap  (sel_wrap),
        .first (sel_first),
        .none  (sel_none)
    );

    always_comb begin
        state_n   = state;
        gap_n     = gap_cnt;
        dwell_n   = dwell_cnt;
        mask_n    = mask_r;
        wrapped_n = wrapped;
        ch_n      = ch;
        g_l_n     = G_L;
        done_n    = 1'b0;
        if (STOP) begin
            state_n = IDLE;
            g_l_n   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        if (sel_none) begin
                            done_n = 1'b1;
                        end else begin
                            // Select lines settle now; the first gap cycle
                            // is already spent, hence entry at count 2.
                            mask_n    = MASK;
                            ch_n      = sel_first;
                            gap_n     = 4'd2;
                            wrapped_n = 1'b0;
                            state_n   = GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'(GAP_CYC)) begin
                        state_n = ACTIVE;
                        g_l_n   = 1'b0;
                        dwell_n = DWELL;
                    end else begin
                        gap_n = gap_cnt + 4'd1;
                        // Select lines move only after one full blanked cycle.
                        if (gap_cnt == 4'd1)
                            ch_n = wrapped ? sel_first : sel_nxt;
                    end
                end
                ACTIVE: begin
                    if (dwell_cnt != '0) begin
                        dwell_n = dwell_cnt - 1'b1;
                    end else begin
                        g_l_n = 1'b1;
                        if (sel_wrap) begin
                            done_n = 1'b1;
                            if (ONESHOT || MASK == 4'd0) begin
                                state_n = IDLE;
                            end else begin
                                mask_n    = MASK;
                                wrapped_n = 1'b1;
                                gap_n     = 4'd1;
                                state_n   = GAP;
                            end
                        end else begin
                            wrapped_n = 1'b0;
                            gap_n     = 4'd1;
                            state_n   = GAP;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    g_l_n   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state     <= IDLE;
            gap_cnt   <= 4'd0;
            dwell_cnt <= '0;
            mask_r    <= 4'd0;
            wrapped   <= 1'b0;
            ch        <= CH0;
            G_L       <= 1'b1;
            DONE      <= 1'b0;
        end else begin
            state     <= state_n;
            gap_cnt   <= gap_n;
            dwell_cnt <= dwell_n;
            mask_r    <= mask_n;
            wrapped   <= wrapped_n;
            ch        <= ch_n;
            G_L       <= g_l_n;
            DONE      <= done_n;
        end
    end

    assign {B, A} = ch;
    assign BUSY   = (state != IDLE);

endmodule
